// File: rtl/da_pkg.sv
// rtl/da_pkg.sv - shared defaults, FSM states and bit-index helper for the DA partial-sum table
package da_pkg;

  localparam int TAP_N_DEF  = 8;
  localparam int COEF_W_DEF = 32;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    BUILD = 2'd1,
    READY = 2'd2
  } da_state_e;

  // Highest set bit of k; k is never 0 when the build calls this.
  function automatic logic [2:0] msb_index(input logic [7:0] k);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/da_lut_ram.sv
// rtl/da_lut_ram.sv - partial-sum flop array: one write, one combinational build read, one registered lookup read
module da_lut_ram #(
  parameter int COEF_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [COEF_W-1:0] wdata,
  input  logic [ADDR_W-1:0] build_addr,
  output logic [COEF_W-1:0] build_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [COEF_W-1:0] rd_data
);

  logic [COEF_W-1:0] mem [2**ADDR_W];

  // Contents are deliberately unreset; only the lookup register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign build_data = mem[build_addr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/da_lut_builder.sv
// rtl/da_lut_builder.sv - loads eight coefficients, builds all 2^TAP_N partial sums, serves lookups
module da_lut_builder
  import da_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF,
  parameter int TAP_N  = TAP_N_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              coef_valid,
  output logic              coef_ready,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              reload,
  output logic              table_valid,
  input  logic              rd_en,
  input  logic [TAP_N-1:0]  addr,
  output logic [COEF_W-1:0] data_out,
  output logic              data_valid
);

  localparam int CNT_W = $clog2(TAP_N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAP_N - 1);

  da_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [TAP_N-1:0]  k_q;
  logic [COEF_W-1:0] b_q [TAP_N];

  logic [CNT_W-1:0]  m;
  logic [TAP_N-1:0]  build_addr;
  logic [COEF_W-1:0] build_data;
  logic              ram_we;
  logic [TAP_N-1:0]  ram_waddr;
  logic [COEF_W-1:0] ram_wdata;
  logic              rd_fire;
  logic              coef_fire;

  // entry[k] = entry[k with its top bit cleared] + b[top bit]
  assign m          = msb_index(k_q);
  assign build_addr = k_q ^ (TAP_N'(1) << m);

  assign coef_ready  = (state_q == LOAD);
  assign table_valid = (state_q == READY);
  assign rd_fire     = (state_q == READY) && rd_en;
  assign coef_fire   = coef_ready && coef_valid && !reload;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ram_we    = 1'b0;
    ram_waddr = k_q;
    ram_wdata = build_data + b_q[m];
    case (state_q)
      LOAD: begin
        if (coef_fire && cnt_q == CNT_LAST) begin
          ram_we    = 1'b1;
          ram_waddr = '0;
          ram_wdata = '0;
          state_d   = BUILD;
        end
      end
      BUILD: begin
        ram_we = 1'b1;
        if (k_q == '1) state_d = READY;
      end
      READY: begin
        if (reload) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      k_q        <= '0;
      data_valid <= 1'b0;
      for (int i = 0; i < TAP_N; i++) b_q[i] <= '0;
    end else begin
      data_valid <= rd_fire;
      case (state_q)
        LOAD: begin
          if (reload) begin
            cnt_q <= '0;
          end else if (coef_fire) begin
            b_q[cnt_q] <= coef_data;
            cnt_q      <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              cnt_q <= '0;
              k_q   <= TAP_N'(1);
            end
          end
        end
        BUILD:   k_q   <= k_q + 1'b1;
        READY:   if (reload) cnt_q <= '0;
        default: cnt_q <= '0;
      endcase
    end
  end

  da_lut_ram #(
    .COEF_W (COEF_W),
    .ADDR_W (TAP_N)
  ) u_ram (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (ram_we),
    .waddr      (ram_waddr),
    .wdata      (ram_wdata),
    .build_addr (build_addr),
    .build_data (build_data),
    .rd_en      (rd_fire),
    .rd_addr    (addr),
    .rd_data    (data_out)
  );

endmodule

// File: tb/tb_da_lut_builder.sv
// tb/tb_da_lut_builder.sv - randomized self-checking bench against a sum-of-set-bits model
module tb_da_lut_builder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        coef_valid;
  logic        coef_ready;
  logic [31:0] coef_data;
  logic        reload;
  logic        table_valid;
  logic        rd_en;
  logic [7:0]  addr;
  logic [31:0] data_out;
  logic        data_valid;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] coef_set [8];
  logic [31:0] model_b  [8];

  always #5 clk = ~clk;

  da_lut_builder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coef_valid  (coef_valid),
    .coef_ready  (coef_ready),
    .coef_data   (coef_data),
    .reload      (reload),
    .table_valid (table_valid),
    .rd_en       (rd_en),
    .addr        (addr),
    .data_out    (data_out),
    .data_valid  (data_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] model(input int a);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) s = s + model_b[i];
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_coefs(input bit stall);
    int got;
    int guard;
    bit hs;
    got   = 0;
    guard = 0;
    while (got < 8 && guard < 2000) begin
      coef_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      coef_data  = coef_set[got];
      hs = coef_valid && coef_ready;
      tick();
      guard++;
      if (hs) begin
        model_b[got] = coef_set[got];
        got++;
      end
    end
    coef_valid = 1'b0;
    check("load_handshakes", 32'(got), 32'd8);
    check("ready_low_in_build", 32'(coef_ready), 32'd0);
  endtask

  task automatic wait_table();
    int cycles;
    int dv_seen;
    cycles  = 0;
    dv_seen = 0;
    while (!table_valid && cycles < 400) begin
      rd_en = 1'($urandom_range(0, 1));
      addr  = 8'($urandom);
      tick();
      cycles++;
      if (data_valid) dv_seen++;
    end
    rd_en = 1'b0;
    check("build_latency", 32'(cycles), 32'd255);
    check("no_dv_in_build", 32'(dv_seen), 32'd0);
  endtask

  task automatic read_one(input string tag, input logic [7:0] a, input logic [31:0] exp);
    addr  = a;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check({tag, "_dv"}, 32'(data_valid), 32'd1);
    check(tag, data_out, exp);
  endtask

  initial begin
    int dv_run;
    int bad;
    logic [31:0] held;

    rst_n      = 1'b0;
    coef_valid = 1'b0;
    coef_data  = '0;
    reload     = 1'b0;
    rd_en      = 1'b0;
    addr       = '0;
    repeat (3) tick();
    rst_n = 1'b1;

    check("rst_table_valid", 32'(table_valid), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_coef_ready", 32'(coef_ready), 32'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("no_dv_in_load", 32'(data_valid), 32'd0);

    coef_set = '{-32'sd94, -32'sd62, 32'sd39, 32'sd22, -32'sd12, -32'sd5, 32'sd1, 32'sd1};
    load_coefs(1'b0);
    wait_table();
    read_one("basic_00", 8'h00, 32'h0000_0000);
    read_one("basic_01", 8'h01, 32'hFFFF_FFA2);
    read_one("basic_03", 8'h03, 32'hFFFF_FF64);
    read_one("basic_0c", 8'h0C, 32'h0000_003D);
    read_one("basic_ff", 8'hFF, 32'hFFFF_FF92);

    // Back-to-back sweep of a randomized table loaded with a stalling source.
    reload = 1'b1;
    tick();
    reload = 1'b0;
    for (int i = 0; i < 8; i++) coef_set[i] = $urandom;
    load_coefs(1'b1);
    wait_table();
    dv_run = 0;
    bad    = 0;
    for (int a = 0; a < 256; a++) begin
      addr  = 8'(a);
      rd_en = 1'b1;
      tick();
      if (data_valid) dv_run++;
      if (data_out !== model(a)) begin
        bad++;
        if (bad <= 4) check("sweep_entry", data_out, model(a));
      end
    end
    rd_en = 1'b0;
    check("sweep_bad_entries", 32'(bad), 32'd0);
    check("sweep_dv_run", 32'(dv_run), 32'd256);
    held = data_out;
    tick();
    check("dv_drops", 32'(data_valid), 32'd0);
    check("data_out_holds", data_out, held);

    // Reload with a concurrent read returns the old table.
    addr   = 8'hFF;
    rd_en  = 1'b1;
    reload = 1'b1;
    tick();
    rd_en  = 1'b0;
    reload = 1'b0;
    check("reload_read_dv", 32'(data_valid), 32'd1);
    check("reload_read_old", data_out, model(255));
    check("reload_table_valid", 32'(table_valid), 32'd0);
    check("reload_coef_ready", 32'(coef_ready), 32'd1);

    for (int i = 0; i < 8; i++) coef_set[i] = 32'h7FFF_FFFF;
    load_coefs(1'b1);
    wait_table();
    read_one("wrap_03", 8'h03, 32'hFFFF_FFFE);
    for (int j = 0; j < 6; j++) begin
      logic [7:0] ra;
      ra = 8'($urandom);
      read_one("wrap_rand", ra, model(int'(ra)));
    end

    // Reset in the middle of BUILD abandons the table.
    reload = 1'b1;
    tick();
    reload = 1'b0;
    for (int i = 0; i < 8; i++) coef_set[i] = $urandom;
    load_coefs(1'b0);
    repeat (99) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_table_valid", 32'(table_valid), 32'd0);
    check("midrst_coef_ready", 32'(coef_ready), 32'd1);
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (table_valid) bad++;
    end
    check("midrst_stays_invalid", 32'(bad), 32'd0);
    for (int i = 0; i < 8; i++) coef_set[i] = 32'd1;
    load_coefs(1'b0);
    wait_table();
    read_one("ones_ff", 8'hFF, 32'd8);
    read_one("ones_0f", 8'h0F, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
